// File: rtl/soduku_pkg.sv
// rtl/soduku_pkg.sv - shared board geometry, state encoding and constants for the sudoku run control
package soduku_pkg;
  localparam int GRID_SIZE = 9;
  localparam int CELL_W    = 4;
  localparam int NUM_CELLS = GRID_SIZE * GRID_SIZE;
  localparam int BOARD_W   = CELL_W * NUM_CELLS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Seed for the previous-result register so the first RUN compare always differs.
  localparam logic [BOARD_W-1:0] BOARD_ONES = '1;
endpackage

// File: rtl/soduku_board_check.sv
// rtl/soduku_board_check.sv - flags a board as fully filled (all cells 1..9) or holding a non-BCD digit
module soduku_board_check
  import soduku_pkg::*;
(
  input  logic [BOARD_W-1:0] board,
  output logic               all_filled,
  output logic               any_invalid
);

  logic [CELL_W-1:0] nib;

  always_comb begin
    all_filled  = 1'b1;
    any_invalid = 1'b0;
    nib         = '0;
    for (int i = 0; i < NUM_CELLS; i++) begin
      nib = board[i*CELL_W +: CELL_W];
      if (nib == CELL_W'(0) || nib > CELL_W'(9)) all_filled = 1'b0;
      if (nib > CELL_W'(9)) any_invalid = 1'b1;
    end
  end

endmodule

// File: rtl/soduku_solve_ctrl.sv
// rtl/soduku_solve_ctrl.sv - loads a board into the solver, waits for convergence or budget, reports status
module soduku_solve_ctrl
  import soduku_pkg::*;
#(
  parameter int RESET_CYCLES  = 2,
  parameter int STABLE_CYCLES = 3,
  parameter int MAX_CYCLES    = 1000,
  parameter int CNT_W         = 16
) (
  input  logic               clk_in,
  input  logic               reset_in,
  input  logic               start_in,
  input  logic [BOARD_W-1:0] board_in,
  output logic               busy_out,
  output logic               done_out,
  output logic               solved_out,
  output logic               stuck_out,
  output logic               error_out,
  output logic               timeout_out,
  output logic [CNT_W-1:0]   cycles_out,
  output logic [BOARD_W-1:0] board_out,
  output logic               solver_reset_out,
  output logic [BOARD_W-1:0] solver_board_out,
  input  logic [BOARD_W-1:0] solver_result_in
);

  state_t             state;
  logic [BOARD_W-1:0] prev;
  logic [CNT_W-1:0]   load_cnt;
  logic [CNT_W-1:0]   stable_cnt;

  logic               unused_in_all_filled;
  logic               in_any_invalid;
  logic               res_all_filled;
  logic               res_any_invalid;
  logic               res_solved;

  logic               same;
  logic [CNT_W-1:0]   stable_nxt;
  logic [CNT_W-1:0]   cycles_nxt;
  logic               converged;
  logic               timed_out;

  soduku_board_check u_in_check (
    .board       (solver_board_out),
    .all_filled  (unused_in_all_filled),
    .any_invalid (in_any_invalid)
  );

  soduku_board_check u_res_check (
    .board       (solver_result_in),
    .all_filled  (res_all_filled),
    .any_invalid (res_any_invalid)
  );

  assign res_solved = res_all_filled & ~res_any_invalid;

  always_comb begin
    same       = (solver_result_in == prev);
    stable_nxt = same ? (stable_cnt + CNT_W'(1)) : '0;
    cycles_nxt = (cycles_out >= CNT_W'(MAX_CYCLES)) ? cycles_out : (cycles_out + CNT_W'(1));
    converged  = (stable_nxt == CNT_W'(STABLE_CYCLES));
    timed_out  = (cycles_nxt == CNT_W'(MAX_CYCLES));
  end

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      state            <= IDLE;
      prev             <= '0;
      load_cnt         <= '0;
      stable_cnt       <= '0;
      busy_out         <= 1'b0;
      done_out         <= 1'b0;
      solved_out       <= 1'b0;
      stuck_out        <= 1'b0;
      error_out        <= 1'b0;
      timeout_out      <= 1'b0;
      cycles_out       <= '0;
      board_out        <= '0;
      solver_reset_out <= 1'b1;
      solver_board_out <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start_in) begin
            state            <= LOAD;
            solver_board_out <= board_in;
            load_cnt         <= '0;
            stable_cnt       <= '0;
            busy_out         <= 1'b1;
            done_out         <= 1'b0;
            solved_out       <= 1'b0;
            stuck_out        <= 1'b0;
            error_out        <= 1'b0;
            timeout_out      <= 1'b0;
            cycles_out       <= '0;
          end
        end
        LOAD: begin
          // The latched board is only judged once, in the first load cycle.
          if (load_cnt == '0 && in_any_invalid) begin
            state     <= DONE;
            error_out <= 1'b1;
            board_out <= solver_board_out;
            busy_out  <= 1'b0;
            done_out  <= 1'b1;
          end else if (load_cnt == CNT_W'(RESET_CYCLES - 1)) begin
            state            <= RUN;
            solver_reset_out <= 1'b0;
            prev             <= BOARD_ONES;
            stable_cnt       <= '0;
            cycles_out       <= '0;
          end else begin
            load_cnt <= load_cnt + CNT_W'(1);
          end
        end
        RUN: begin
          cycles_out <= cycles_nxt;
          stable_cnt <= stable_nxt;
          prev       <= solver_result_in;
          // Convergence takes priority over an expiring budget in the same cycle.
          if (converged || timed_out) begin
            state            <= DONE;
            board_out        <= solver_result_in;
            solved_out       <= res_solved;
            stuck_out        <= ~res_solved;
            timeout_out      <= ~converged;
            busy_out         <= 1'b0;
            done_out         <= 1'b1;
            solver_reset_out <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_soduku_solve_ctrl.sv
// tb/tb_soduku_solve_ctrl.sv - scoreboard bench for soduku_solve_ctrl with a behavioural solver model
module tb_soduku_solve_ctrl;
  import soduku_pkg::*;

  localparam int CNT_W = 16;

  logic               clk_in = 1'b0;
  logic               reset_in;
  logic               start_in;
  logic [BOARD_W-1:0] board_in;
  logic               busy_out, done_out, solved_out, stuck_out, error_out, timeout_out;
  logic [CNT_W-1:0]   cycles_out;
  logic [BOARD_W-1:0] board_out;
  logic               solver_reset_out;
  logic [BOARD_W-1:0] solver_board_out;
  logic [BOARD_W-1:0] solver_result_in;

  soduku_solve_ctrl #(
    .RESET_CYCLES(2), .STABLE_CYCLES(3), .MAX_CYCLES(1000), .CNT_W(CNT_W)
  ) dut (
    .clk_in           (clk_in),
    .reset_in         (reset_in),
    .start_in         (start_in),
    .board_in         (board_in),
    .busy_out         (busy_out),
    .done_out         (done_out),
    .solved_out       (solved_out),
    .stuck_out        (stuck_out),
    .error_out        (error_out),
    .timeout_out      (timeout_out),
    .cycles_out       (cycles_out),
    .board_out        (board_out),
    .solver_reset_out (solver_reset_out),
    .solver_board_out (solver_board_out),
    .solver_result_in (solver_result_in)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    string              name;
    logic               solved;
    logic               stuck;
    logic               error;
    logic               timeout;
    logic [CNT_W-1:0]   cycles;
    logic [BOARD_W-1:0] board;
    int                 latency;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   last_start = 0;
  logic done_q = 1'b0;

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [BOARD_W-1:0] act, input logic [BOARD_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Solver model: mode 0 echoes the board, mode 1 fills cell (0,0) with 2 on its
  // third free-running cycle, mode 2 emits a pattern that changes every cycle.
  int mode = 0;
  int scnt = 0;
  logic [BOARD_W-1:0] sres = '0;
  assign solver_result_in = sres;

  always @(posedge clk_in) begin
    if (solver_reset_out) begin
      sres <= solver_board_out;
      scnt <= 0;
    end else begin
      scnt <= scnt + 1;
      if (mode == 1 && scnt + 1 == 3) sres[BOARD_W-1 -: 4] <= 4'd2;
      if (mode == 2) sres <= {{(BOARD_W-32){1'b0}}, 32'(scnt + 1)};
    end
  end

  always @(negedge clk_in) begin
    if (reset_in && done_out && !done_q) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk({e.name, ".solved"},  BOARD_W'(solved_out),  BOARD_W'(e.solved));
        chk({e.name, ".stuck"},   BOARD_W'(stuck_out),   BOARD_W'(e.stuck));
        chk({e.name, ".error"},   BOARD_W'(error_out),   BOARD_W'(e.error));
        chk({e.name, ".timeout"}, BOARD_W'(timeout_out), BOARD_W'(e.timeout));
        chk({e.name, ".cycles"},  BOARD_W'(cycles_out),  BOARD_W'(e.cycles));
        chk({e.name, ".board"},   board_out,             e.board);
        chk({e.name, ".latency"}, BOARD_W'(cyc - last_start), BOARD_W'(e.latency));
        chk({e.name, ".busy"},    BOARD_W'(busy_out),    BOARD_W'(0));
      end
    end
    done_q = done_out;
  end

  function automatic logic [BOARD_W-1:0] make_solved();
    logic [BOARD_W-1:0] b;
    int r0[9] = '{2, 5, 4, 8, 1, 3, 6, 9, 7};
    int sh[9] = '{0, 3, 6, 1, 4, 7, 2, 5, 8};
    b = '0;
    for (int r = 0; r < 9; r++)
      for (int c = 0; c < 9; c++)
        b[BOARD_W-1-4*(r*9+c) -: 4] = 4'(r0[(c + sh[r]) % 9]);
    return b;
  endfunction

  task automatic push_exp(input string name, input logic s, input logic k, input logic e, input logic t,
                          input int cycles, input logic [BOARD_W-1:0] board, input int latency);
    exp_t x;
    x.name = name; x.solved = s; x.stuck = k; x.error = e; x.timeout = t;
    x.cycles = CNT_W'(cycles); x.board = board; x.latency = latency;
    exp_q.push_back(x);
  endtask

  task automatic issue(input logic [BOARD_W-1:0] b);
    @(negedge clk_in);
    board_in = b;
    start_in = 1'b1;
    @(posedge clk_in);
    #1;
    last_start = cyc;
    start_in = 1'b0;
  endtask

  task automatic wait_done(input string name, input int limit, output logic rst_low_seen);
    int n = 0;
    rst_low_seen = 1'b0;
    while (!done_out && n < limit) begin
      @(negedge clk_in);
      if (!solver_reset_out) rst_low_seen = 1'b1;
      n++;
    end
    if (!done_out) chk({name, ".done_timeout"}, 0, 1);
    @(negedge clk_in);
  endtask

  logic [BOARD_W-1:0] b_solved, b_hole, b_err;
  logic               rl;

  initial begin
    b_solved = make_solved();
    b_hole   = b_solved;
    b_hole[BOARD_W-1 -: 4] = 4'd0;
    b_err    = '0;
    b_err[BOARD_W-1-4*40 -: 4] = 4'hA;

    reset_in = 1'b0;
    start_in = 1'b0;
    board_in = '0;
    repeat (3) @(negedge clk_in);
    chk("rst.busy", BOARD_W'(busy_out), 0);
    chk("rst.done", BOARD_W'(done_out), 0);
    chk("rst.flags", BOARD_W'({solved_out, stuck_out, error_out, timeout_out}), 0);
    chk("rst.cycles", BOARD_W'(cycles_out), 0);
    chk("rst.board_out", board_out, 0);
    chk("rst.solver_board", solver_board_out, 0);
    chk("rst.solver_reset", BOARD_W'(solver_reset_out), 1);
    reset_in = 1'b1;

    mode = 0;
    push_exp("solved", 1, 0, 0, 0, 4, b_solved, 6);
    issue(b_solved);
    wait_done("solved", 20, rl);

    mode = 1;
    push_exp("hole", 1, 0, 0, 0, 7, b_solved, 9);
    issue(b_hole);
    wait_done("hole", 30, rl);

    mode = 2;
    push_exp("timeout", 0, 1, 0, 1, 1000, BOARD_W'(999), 1002);
    issue('0);
    wait_done("timeout", 1100, rl);

    mode = 0;
    push_exp("error", 0, 0, 1, 0, 0, b_err, 1);
    issue(b_err);
    wait_done("error", 20, rl);
    chk("error.solver_reset_held", BOARD_W'(rl), 0);

    push_exp("ignore_start", 1, 0, 0, 0, 4, b_solved, 6);
    issue(b_solved);
    repeat (3) @(negedge clk_in);
    board_in = '0;
    start_in = 1'b1;
    @(negedge clk_in);
    start_in = 1'b0;
    chk("ignore_start.busy", BOARD_W'(busy_out), 1);
    wait_done("ignore_start", 20, rl);

    mode = 1;
    push_exp("restart", 1, 0, 0, 0, 7, b_solved, 9);
    issue(b_hole);
    chk("restart.done_drop", BOARD_W'(done_out), 0);
    chk("restart.busy", BOARD_W'(busy_out), 1);
    wait_done("restart", 30, rl);

    mode = 0;
    issue(b_solved);
    repeat (4) @(negedge clk_in);
    #2;
    reset_in = 1'b0;
    #1;
    chk("midrst.busy", BOARD_W'(busy_out), 0);
    chk("midrst.done", BOARD_W'(done_out), 0);
    chk("midrst.flags", BOARD_W'({solved_out, stuck_out, error_out, timeout_out}), 0);
    chk("midrst.cycles", BOARD_W'(cycles_out), 0);
    chk("midrst.board_out", board_out, 0);
    chk("midrst.solver_board", solver_board_out, 0);
    chk("midrst.solver_reset", BOARD_W'(solver_reset_out), 1);
    @(negedge clk_in);
    reset_in = 1'b1;

    mode = 1;
    push_exp("after_rst", 1, 0, 0, 0, 7, b_solved, 9);
    issue(b_hole);
    wait_done("after_rst", 30, rl);

    chk("queue_empty", BOARD_W'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
